// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC and the writeback FSM states.
package cpu_pkg;
  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int RD_W   = 6;
  localparam int CNT_W  = 3;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic {ST_RUN = 1'b0, ST_SQUASH = 1'b1} state_e;

  // Redirect-related controls and flags from the EX/WB register.
  typedef struct packed {
    logic branch_neg;
    logic branch_z;
    logic jump;
    logic jump_mem;
    logic n;
    logic z;
  } redir_ctrl_t;
endpackage

// File: rtl/wb_redirect_decode.sv
// Redirect decode: decides whether the instruction redirects and where to.
// Purely combinational so the hazard unit can reuse it.
module wb_redirect_decode
  import cpu_pkg::*;
(
  input  redir_ctrl_t       ctrl,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] datamem,
  output logic              taken,
  output logic [PC_W-1:0]   target
);

  // jump_mem targets the loaded word; every other redirect goes to alu.
  always_comb begin
    taken  = ctrl.jump_mem | ctrl.jump | (ctrl.branch_z & ctrl.z) |
             (ctrl.branch_neg & ctrl.n);
    target = ctrl.jump_mem ? datamem[PC_W-1:0] : alu[PC_W-1:0];
  end

endmodule

// File: rtl/wb_pc_unit.sv
// Writeback and PC-redirect stage: register-file write port, PC register,
// and the squash sequencer that flushes younger instructions after a redirect.
module wb_pc_unit
  import cpu_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] datamem,
  input  logic [PC_W-1:0]   addr,
  input  logic [RD_W-1:0]   rd,
  input  logic              n,
  input  logic              z,
  input  logic              reg_write,
  input  logic              memtoreg,
  input  logic              pctoreg,
  input  logic              branch_neg,
  input  logic              branch_z,
  input  logic              jump,
  input  logic              jump_mem,
  input  logic              pc_hold,
  output logic [PC_W-1:0]   pc,
  output logic              rf_we,
  output logic [RD_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flush
);

  localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              taken;
  logic [PC_W-1:0]   target;
  redir_ctrl_t       ctrl;

  assign ctrl = '{branch_neg: branch_neg, branch_z: branch_z, jump: jump,
                  jump_mem: jump_mem, n: n, z: z};

  wb_redirect_decode u_decode (
    .ctrl    (ctrl),
    .alu     (alu),
    .datamem (datamem),
    .taken   (taken),
    .target  (target)
  );

  // State, squash counter and PC registers; reset aborts any squash in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // Next state: a redirect starts a squash; the last squashed slot returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (taken) state_d = ST_SQUASH;
      ST_SQUASH: if (!pc_hold && cnt_q == CNT_W'(1)) state_d = ST_RUN;
    endcase
  end

  // PC and counter update; a redirect overrides a stall, a stall freezes a squash.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (state_q == ST_RUN) begin
      if (taken) begin
        pc_d  = target;
        cnt_d = FLUSH_CNT;
      end else if (!pc_hold) begin
        pc_d = pc_q + PC_W'(1);
      end
    end else if (!pc_hold) begin
      pc_d  = pc_q + PC_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Outputs: squashed slots never write back; nothing is asserted during reset.
  always_comb begin
    rf_we    = rst_n & reg_write & (state_q == ST_RUN);
    flush    = rst_n & (((state_q == ST_RUN) & taken) | (state_q == ST_SQUASH));
    rf_waddr = rd;
    rf_wdata = pctoreg ? DATA_W'(addr) : (memtoreg ? datamem : alu);
    pc       = pc_q;
  end

endmodule
